// File: rtl/mup_resp_if.sv
// Panel-side RS-485 responder signal bundle: serial line, transceiver direction,
// panel I/O words and status strobes. The responder uses the slave view.
interface mup_resp_if;
    logic        data_i;
    logic        data_o;
    logic        dir_485;
    logic [2:0]  my_addr;
    logic [15:0] but;
    logic [23:0] an_data;
    logic [15:0] led;
    logic        led_stb;
    logic        frame_err;
    logic        busy;

    modport slave (
        input  data_i, my_addr, but, an_data,
        output data_o, dir_485, led, led_stb, frame_err, busy
    );

    modport master (
        output data_i, my_addr, but, an_data,
        input  data_o, dir_485, led, led_stb, frame_err, busy
    );
endinterface

// File: rtl/mup_resp.sv
// MUP poll responder: decodes a 4-byte 8N1 request addressed to this unit, latches
// the LED word and answers after a fixed turnaround with a 7-byte button/analog reply.
module mup_resp #(
    parameter int BIT_DIV   = 16,
    parameter int TURN_BITS = 2,
    parameter int GAP_BITS  = 12
) (
    input  logic      clk,
    input  logic      rst,
    input  logic      clk_en,
    mup_resp_if.slave bus
);
    localparam int HALF     = BIT_DIV / 2;
    localparam int GAP_LIM  = GAP_BITS * BIT_DIV + HALF;
    localparam int TURN_LIM = TURN_BITS * BIT_DIV;
    localparam int CNT_W    = $clog2(GAP_LIM + TURN_LIM + BIT_DIV + 1);
    localparam logic [4:0] REQ_HDR = 5'b10100;
    localparam logic [4:0] RSP_HDR = 5'b01010;

    typedef enum logic [2:0] {S_IDLE, S_RX, S_CHK, S_TURN, S_TX} state_e;

    state_e           state_q, state_d;
    logic             s1_q, s2_q, prev_q;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [3:0]       bit_q, bit_d;
    logic [2:0]       byte_q, byte_d;
    logic             gap_q, gap_d;
    logic [7:0]       sh_q, sh_d, b0_q, b0_d, b1_q, b1_d, b2_q, b2_d, b3_q, b3_d;
    logic [15:0]      led_q, led_d, but_q, but_d;
    logic [23:0]      an_q, an_d;
    logic             tx_q, tx_d, dir_q, dir_d, busy_q, busy_d;
    logic             stb_q, stb_d, err_q, err_d;
    logic             fall;
    logic [7:0]       rsp_csum, tx_byte;

    assign fall = prev_q & ~s2_q;

    assign rsp_csum = {RSP_HDR, bus.my_addr} ^ but_q[15:8] ^ but_q[7:0]
                    ^ an_q[23:16] ^ an_q[15:8] ^ an_q[7:0];

    always_comb begin
        case (byte_q)
            3'd0:    tx_byte = {RSP_HDR, bus.my_addr};
            3'd1:    tx_byte = but_q[15:8];
            3'd2:    tx_byte = but_q[7:0];
            3'd3:    tx_byte = an_q[23:16];
            3'd4:    tx_byte = an_q[15:8];
            3'd5:    tx_byte = an_q[7:0];
            default: tx_byte = rsp_csum;
        endcase
    end

    // NOTE: every next-state signal gets its hold value first so no path infers a latch.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        bit_d   = bit_q;
        byte_d  = byte_q;
        gap_d   = gap_q;
        sh_d    = sh_q;
        b0_d    = b0_q;
        b1_d    = b1_q;
        b2_d    = b2_q;
        b3_d    = b3_q;
        led_d   = led_q;
        but_d   = but_q;
        an_d    = an_q;
        tx_d    = tx_q;
        dir_d   = dir_q;
        busy_d  = busy_q;
        stb_d   = 1'b0;
        err_d   = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (fall) begin
                    state_d = S_RX;
                    cnt_d   = '0;
                    bit_d   = 4'd0;
                    byte_d  = 3'd0;
                    gap_d   = 1'b0;
                end
            end

            S_RX: begin
                cnt_d = cnt_q + 1'b1;
                if (gap_q) begin
                    if (fall) begin
                        gap_d = 1'b0;
                        bit_d = 4'd0;
                        cnt_d = '0;
                    end else if (cnt_q == CNT_W'(GAP_LIM)) begin
                        state_d = S_IDLE;
                    end
                end else if (bit_q == 4'd0) begin
                    if (cnt_q == CNT_W'(HALF - 1)) begin
                        cnt_d = '0;
                        bit_d = 4'd1;
                        if (s2_q) state_d = S_IDLE;
                    end
                end else if (cnt_q == CNT_W'(BIT_DIV - 1)) begin
                    cnt_d = '0;
                    if (bit_q != 4'd9) begin
                        sh_d  = {s2_q, sh_q[7:1]};
                        bit_d = bit_q + 4'd1;
                    end else if (!s2_q || (byte_q == 3'd0 && sh_q[7:3] != REQ_HDR)) begin
                        err_d   = 1'b1;
                        state_d = S_IDLE;
                    end else begin
                        gap_d  = 1'b1;
                        byte_d = byte_q + 3'd1;
                        case (byte_q)
                            3'd0:    b0_d = sh_q;
                            3'd1:    b1_d = sh_q;
                            3'd2:    b2_d = sh_q;
                            default: begin
                                b3_d    = sh_q;
                                gap_d   = 1'b0;
                                state_d = S_CHK;
                            end
                        endcase
                    end
                end
            end

            S_CHK: begin
                if ((b0_q ^ b1_q ^ b2_q) != b3_q) begin
                    err_d   = 1'b1;
                    state_d = S_IDLE;
                end else if (b0_q[2:0] != bus.my_addr) begin
                    state_d = S_IDLE;
                end else begin
                    led_d   = {b1_q, b2_q};
                    stb_d   = 1'b1;
                    but_d   = bus.but;
                    an_d    = bus.an_data;
                    busy_d  = 1'b1;
                    cnt_d   = '0;
                    state_d = S_TURN;
                end
            end

            S_TURN: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CNT_W'(TURN_LIM - 1)) begin
                    state_d = S_TX;
                    dir_d   = 1'b1;
                    tx_d    = 1'b0;
                    cnt_d   = '0;
                    bit_d   = 4'd0;
                    byte_d  = 3'd0;
                end
            end

            S_TX: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CNT_W'(BIT_DIV - 1)) begin
                    cnt_d = '0;
                    if (bit_q == 4'd9) begin
                        if (byte_q == 3'd6) begin
                            // Last stop bit done: release the bus and clear busy together.
                            state_d = S_IDLE;
                            dir_d   = 1'b0;
                            busy_d  = 1'b0;
                            tx_d    = 1'b1;
                        end else begin
                            byte_d = byte_q + 3'd1;
                            bit_d  = 4'd0;
                            tx_d   = 1'b0;
                        end
                    end else begin
                        bit_d = bit_q + 4'd1;
                        tx_d  = (bit_q == 4'd8) ? 1'b1 : tx_byte[bit_q[2:0]];
                    end
                end
            end

            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            s1_q    <= 1'b1;
            s2_q    <= 1'b1;
            prev_q  <= 1'b1;
            cnt_q   <= '0;
            bit_q   <= 4'd0;
            byte_q  <= 3'd0;
            gap_q   <= 1'b0;
            sh_q    <= 8'h00;
            b0_q    <= 8'h00;
            b1_q    <= 8'h00;
            b2_q    <= 8'h00;
            b3_q    <= 8'h00;
            led_q   <= 16'h0000;
            but_q   <= 16'h0000;
            an_q    <= 24'h000000;
            tx_q    <= 1'b1;
            dir_q   <= 1'b0;
            busy_q  <= 1'b0;
            stb_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            // Strobes last exactly one clk even when clk_en is sparse.
            stb_q <= clk_en & stb_d;
            err_q <= clk_en & err_d;
            if (clk_en) begin
                state_q <= state_d;
                s1_q    <= bus.data_i;
                s2_q    <= s1_q;
                prev_q  <= s2_q;
                cnt_q   <= cnt_d;
                bit_q   <= bit_d;
                byte_q  <= byte_d;
                gap_q   <= gap_d;
                sh_q    <= sh_d;
                b0_q    <= b0_d;
                b1_q    <= b1_d;
                b2_q    <= b2_d;
                b3_q    <= b3_d;
                led_q   <= led_d;
                but_q   <= but_d;
                an_q    <= an_d;
                tx_q    <= tx_d;
                dir_q   <= dir_d;
                busy_q  <= busy_d;
            end
        end
    end

    assign bus.data_o    = tx_q;
    assign bus.dir_485   = dir_q;
    assign bus.led       = led_q;
    assign bus.led_stb   = stb_q;
    assign bus.frame_err = err_q;
    assign bus.busy      = busy_q;
endmodule

// File: tb/tb_mup_resp.sv
// Scoreboard bench for mup_resp: a frame-level reference model queues expected LED
// strobes, errors and reply bytes; a UART monitor on the looped-back line checks them.
module tb_mup_resp;
    localparam int BD      = 4;
    localparam int TURN    = 2;
    localparam int GAP     = 12;
    localparam int HALF    = BD / 2;
    localparam logic [2:0] MY_ADDR = 3'd3;
    // Stop-bit mid-sample trails the end of the driven stop bit by 3 sync/edge ticks minus half a bit.
    localparam int EXP_LAT = 1 + TURN * BD + 3 - (BD - HALF);

    typedef struct packed {
        logic [3:0][7:0] b;
        int              n;
        int              bad_stop;
        int              gap;
    } frame_t;

    logic clk = 1'b0, rst = 1'b1, clk_en = 1'b1, drv_line = 1'b1, en_rand = 1'b0, en_s;
    int unsigned tick_n = 0, last_req_end = 0, dir_rise_tick = 0;
    int n_checks = 0, n_fail = 0, exp_err = 0, err_seen = 0;
    logic [7:0]  exp_reply[$];
    logic [15:0] exp_led[$];
    logic [15:0] model_led = 16'h0000;

    logic prev_do = 1'b1, prev_dir = 1'b0, prev_stb = 1'b0, in_byte = 1'b0;
    int bcnt = 0, rbyte_idx = 0;
    logic [7:0] rsh = 8'h00;

    mup_resp_if bus();
    // Half-duplex line: while the responder drives, it hears its own echo.
    assign bus.data_i  = bus.dir_485 ? bus.data_o : drv_line;
    assign bus.my_addr = MY_ADDR;

    mup_resp #(.BIT_DIV(BD), .TURN_BITS(TURN), .GAP_BITS(GAP)) dut (
        .clk(clk), .rst(rst), .clk_en(clk_en), .bus(bus)
    );

    always #5 clk = ~clk;
    always @(negedge clk) clk_en = en_rand ? ($urandom_range(0, 3) != 0) : 1'b1;
    always @(posedge clk) if (clk_en) tick_n++;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Monitor: strobes every clk, serial decode of the reply on clk_en ticks.
    always begin
        @(posedge clk);
        en_s = clk_en;
        #1;
        if (rst) begin
            in_byte = 1'b0; prev_do = 1'b1; prev_dir = 1'b0; prev_stb = 1'b0;
        end else begin
            if (bus.led_stb) begin
                check("stb_not_with_err", bus.frame_err, 1'b0);
                check("stb_width", prev_stb, 1'b0);
                check("stb_busy", bus.busy, 1'b1);
                check("stb_expected", exp_led.size() > 0, 1'b1);
                if (exp_led.size() > 0) check("led_value", bus.led, exp_led.pop_front());
            end
            if (bus.frame_err) err_seen++;
            if (bus.dir_485 && !prev_dir) begin
                dir_rise_tick = tick_n;
                rbyte_idx = 0;
            end
            if (!bus.dir_485 && prev_dir) begin
                check("dir_ticks", tick_n - dir_rise_tick, 70 * BD);
                check("busy_with_dir", bus.busy, 1'b0);
                check("line_released", bus.data_o, 1'b1);
            end
            if (en_s) begin
                if (in_byte) begin
                    bcnt++;
                    if (bcnt > HALF && bcnt < HALF + 9 * BD && (bcnt - HALF) % BD == 0)
                        rsh = {bus.data_o, rsh[7:1]};
                    else if (bcnt == HALF + 9 * BD) begin
                        check("reply_stop", bus.data_o, 1'b1);
                        check("reply_expected", exp_reply.size() > 0, 1'b1);
                        if (exp_reply.size() > 0)
                            check($sformatf("reply_byte%0d", rbyte_idx), rsh, exp_reply.pop_front());
                        rbyte_idx++;
                        in_byte = 1'b0;
                    end
                end else if (prev_do && !bus.data_o) begin
                    in_byte = 1'b1;
                    bcnt = 0;
                    check("tx_under_dir", bus.dir_485, 1'b1);
                    if (rbyte_idx == 0) check("turnaround", tick_n - last_req_end, EXP_LAT);
                end
                prev_do = bus.data_o;
            end
            prev_dir = bus.dir_485;
            prev_stb = bus.led_stb;
        end
    end

    task automatic wait_ticks(input int n);
        int k = 0;
        while (k < n) begin
            @(posedge clk);
            if (clk_en) k++;
        end
        #1;
    endtask

    task automatic send_bit(input logic v);
        drv_line = v;
        wait_ticks(BD);
    endtask

    task automatic idle_bits(input int n);
        for (int i = 0; i < n; i++) send_bit(1'b1);
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(b[i]);
        send_bit(stop);
        last_req_end = tick_n;
    endtask

    function automatic frame_t req(input logic [2:0] addr, input logic [15:0] lv);
        frame_t f;
        f.b[0] = {5'b10100, addr};
        f.b[1] = lv[15:8];
        f.b[2] = lv[7:0];
        f.b[3] = f.b[0] ^ f.b[1] ^ f.b[2];
        f.n = 4; f.bad_stop = -1; f.gap = 0;
        return f;
    endfunction

    // Frame-level outcome: first failing rule wins, otherwise a reply if addressed to us.
    function automatic void model(input frame_t f);
        logic [7:0] r[7];
        if (f.bad_stop >= 0) exp_err++;
        else if (f.b[0][7:3] != 5'b10100) exp_err++;
        else if (f.n < 4) begin end
        else if ((f.b[0] ^ f.b[1] ^ f.b[2]) != f.b[3]) exp_err++;
        else if (f.b[0][2:0] == MY_ADDR) begin
            model_led = {f.b[1], f.b[2]};
            exp_led.push_back(model_led);
            r[0] = {5'b01010, MY_ADDR};
            r[1] = bus.but[15:8];     r[2] = bus.but[7:0];
            r[3] = bus.an_data[23:16]; r[4] = bus.an_data[15:8]; r[5] = bus.an_data[7:0];
            r[6] = r[0] ^ r[1] ^ r[2] ^ r[3] ^ r[4] ^ r[5];
            for (int i = 0; i < 7; i++) exp_reply.push_back(r[i]);
        end
    endfunction

    task automatic drive(input frame_t f);
        for (int i = 0; i < f.n; i++) send_byte(f.b[i], (i == f.bad_stop) ? 1'b0 : 1'b1);
        if (f.gap != 0) idle_bits(GAP + 1);
    endtask

    task automatic wait_reply_done();
        int k = 0;
        while ((exp_reply.size() > 0 || bus.busy) && k < 5000) begin
            @(posedge clk);
            #1;
            k++;
        end
        check("reply_in_budget", k < 5000, 1'b1);
    endtask

    task automatic run_frame(input frame_t f, input bit poke);
        model(f);
        drive(f);
        if (poke) begin
            idle_bits(1);
            check("busy_in_turn", bus.busy, 1'b1);
            check("dir_low_in_turn", bus.dir_485, 1'b0);
            bus.but = 16'h0000;
        end
        idle_bits(3);
        wait_reply_done();
        idle_bits(1);
        check("frame_err_count", err_seen, exp_err);
        check("led_word", bus.led, model_led);
        check("led_stb_consumed", exp_led.size(), 0);
        check("line_idle", {bus.dir_485, bus.data_o}, 2'b01);
    endtask

    initial begin
        frame_t f;
        int k;
        bus.but = 16'hBEEF;
        bus.an_data = 24'h123456;
        repeat (3) @(negedge clk);
        check("rst_data_o", bus.data_o, 1'b1);
        check("rst_dir", bus.dir_485, 1'b0);
        check("rst_led", bus.led, 16'h0000);
        check("rst_strobes", {bus.led_stb, bus.frame_err}, 2'b00);
        check("rst_busy", bus.busy, 1'b0);
        rst = 1'b0;
        idle_bits(2);

        // Addressed request, button word changed during turnaround.
        run_frame(req(MY_ADDR, 16'h1234), 1'b1);
        bus.but = 16'hBEEF;
        // Other address, bad checksum, bad stop on B1, partial frame dropped by gap.
        run_frame(req(3'd5, 16'h1234), 1'b0);
        f = req(MY_ADDR, 16'h1234); f.b[3] = 8'h00;
        run_frame(f, 1'b0);
        f = req(MY_ADDR, 16'hA55A); f.n = 2; f.bad_stop = 1;
        run_frame(f, 1'b0);
        run_frame(req(MY_ADDR, 16'h0F0F), 1'b0);
        f = req(MY_ADDR, 16'h1234); f.n = 2; f.gap = 1;
        run_frame(f, 1'b0);
        run_frame(req(MY_ADDR, 16'h1234), 1'b0);

        // One-tick low glitch must not start a byte or flag an error.
        drv_line = 1'b0;
        wait_ticks(1);
        idle_bits(3);
        check("glitch_no_err", err_seen, exp_err);
        check("glitch_no_reply", bus.busy, 1'b0);

        // Reset during the third reply byte.
        model(req(MY_ADDR, 16'hC3C3));
        drive(req(MY_ADDR, 16'hC3C3));
        k = 0;
        while (!(rbyte_idx == 2 && in_byte) && k < 5000) begin
            @(posedge clk); #1; k++;
        end
        check("third_byte_reached", k < 5000, 1'b1);
        wait_ticks(3);
        #2;
        rst = 1'b1;
        #1;
        check("rst_tx_data_o", bus.data_o, 1'b1);
        check("rst_tx_dir", bus.dir_485, 1'b0);
        check("rst_tx_busy", bus.busy, 1'b0);
        exp_reply.delete();
        model_led = 16'h0000;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        check("rst_tx_led", bus.led, 16'h0000);
        idle_bits(2);
        run_frame(req(MY_ADDR, 16'h8001), 1'b0);

        // Randomised frames with a sparse clock enable.
        en_rand = 1'b1;
        for (int i = 0; i < 25; i++) begin
            int ty;
            logic [2:0] ad;
            logic [15:0] lv;
            bus.but = 16'($urandom);
            bus.an_data = 24'($urandom);
            lv = 16'($urandom);
            ty = $urandom_range(0, 5);
            f = req(MY_ADDR, lv);
            case (ty)
                1: begin
                    ad = 3'($urandom_range(0, 6));
                    if (ad >= MY_ADDR) ad = ad + 3'd1;
                    f = req(ad, lv);
                end
                2: f.b[3] = f.b[3] ^ 8'($urandom_range(1, 255));
                3: begin
                    f.b[0] = 8'($urandom);
                    if (f.b[0][7:3] == 5'b10100) f.b[0][3] = ~f.b[0][3];
                    f.n = 1;
                end
                4: begin
                    f.n = $urandom_range(1, 4);
                    f.bad_stop = f.n - 1;
                end
                5: begin
                    f.n = $urandom_range(1, 3);
                    f.gap = 1;
                end
                default: begin end
            endcase
            run_frame(f, 1'b0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #900000;
        n_fail++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/mup_resp.md
Name: mup_resp

Overview:
- Panel-side (MUP) responder for the RS-485 poll link. It is the far end of the host poll engine.
- Receives a poll frame addressed to this unit and latches the 16-bit LED word from it.
- Replies after a fixed turnaround with a snapshot of the 16 button lines and the 24-bit analog word, driving the transceiver direction line.
- Sits in the panel FPGA between the 485 transceiver and the button/LED/ADC logic.

Parameters:
- BIT_DIV, 16, clk_en ticks per serial bit (min 4, even).
- TURN_BITS, 2, idle bit times between request stop bit and dir_485 assertion.
- GAP_BITS, 12, max idle bit times between request bytes before the frame is abandoned.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous reset, active-high
- clk_en  in  1  clock enable; all state advances only on clk edges with clk_en=1
- data_i  in  1  serial RX from 485 receiver (idle high)
- data_o  out  1  serial TX to 485 driver (idle high)
- dir_485  out  1  1 = transmit, 0 = receive
- my_addr  in  3  this unit's address (static)
- but  in  16  button inputs
- an_data  in  24  analog data word
- led  out  16  LED word from the last valid request
- led_stb  out  1  one-clk pulse when led updates
- frame_err  out  1  one-clk pulse on bad frame (framing, checksum, header)
- busy  out  1  1 from valid request accepted until reply stop bit sent

Behaviour:
- Reset values: data_o=1, dir_485=0, led=0, led_stb=0, frame_err=0, busy=0, FSM=IDLE. Reset mid-transmit releases the bus immediately (async).
- Byte format: 8N1, LSB first, BIT_DIV ticks per bit.
- RX: data_i passes through a 2-FF sync. A falling edge starts a byte.
  - Start bit re-checked at BIT_DIV/2; high there = glitch, return to hunt with no error.
  - Data bits sampled at mid-bit.
  - Stop bit sampled at mid-bit; stop=0 means framing error.
- Request frame, 4 bytes:
  - B0 = {5'b10100, addr}
  - B1 = led[15:8]
  - B2 = led[7:0]
  - B3 = B0^B1^B2
- Reply frame, 7 bytes:
  - {5'b01010, my_addr}
  - but[15:8], but[7:0]
  - an_data[23:16], an_data[15:8], an_data[7:0]
  - XOR of the previous 6 bytes
- FSM:
  - IDLE: waiting for a start bit → RX.
  - RX: collect bytes.
    - After B0, if B0[7:3] != 5'b10100 → frame_err, IDLE.
    - Idle longer than GAP_BITS bit times between bytes → IDLE, no error (partial frame dropped).
    - After B3 → CHK.
  - CHK, one clk_en cycle:
    - Bad checksum → frame_err, IDLE.
    - Good checksum, addr != my_addr → IDLE silently. led unchanged, no error.
    - Good checksum, addr == my_addr → led <= {B1,B2}, led_stb=1, but/an_data snapshotted, busy=1 → TURN.
  - TURN: wait TURN_BITS*BIT_DIV ticks with data_o=1, then dir_485=1 → TX.
  - TX: shift the 7 reply bytes back-to-back with no idle between bytes.
  - DONE: after the last stop bit completes, dir_485=0 and busy=0 on the same cycle → IDLE.
- Framing error on any request byte → frame_err, IDLE.
- RX is ignored (sync'd but not decoded) while dir_485=1 and during TURN; own echo never decodes.
- but/an_data changes after CHK do not affect the reply in flight.
- led_stb and frame_err are never both asserted in the same cycle.
- Latency from the request B3 stop-bit mid-sample to the first reply start-bit edge = 1 + TURN_BITS*BIT_DIV clk_en ticks.

Test Plan:
- BIT_DIV=4, my_addr=3, request A3 12 34 85 → led=0x1234, one led_stb pulse, busy=1. Reply 53 BE EF 12 34 56 72 with but=0xBEEF, an_data=0x123456. dir_485 high exactly across 7*10*4 ticks, then dir_485=0 and busy=0.
- Request A5 12 34 83 (addr 5, valid checksum) to my_addr=3 → no reply, led unchanged, no frame_err.
- Request A3 12 34 00 (bad checksum) → frame_err pulse, no reply, led unchanged.
- Stop bit forced 0 on B1 → frame_err; a following valid frame is accepted normally.
- A3 12 sent, then idle for 13 bit times, then full valid frame → first partial frame dropped silently, second frame answered.
- rst asserted during the 3rd reply byte → data_o=1 and dir_485=0 immediately; a next valid request is answered correctly.
- Change but to 0x0000 during TURN → reply still carries BE EF.
